// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline control definitions: hazard FSM encoding,
// forwarding select codes and write-back source codes.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam logic [1:0] WB_SEL_MEM = 2'b00;
    localparam logic [1:0] WB_SEL_ALU = 2'b01;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// EX operand forwarding compare for one source register.
// The youngest producer (MEM) wins over WB; x0 never forwards.
module fwd_unit
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] ex_rs,
    input  logic [4:0] mem_rd,
    input  logic       mem_wb_en,
    input  logic [4:0] wb_rd,
    input  logic       wb_wb_en,
    output logic [1:0] sel
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = mem_wb_en && (mem_rd != 5'd0) && (mem_rd == ex_rs);
    assign wb_hit  = wb_wb_en && (wb_rd != 5'd0) && (wb_rd == ex_rs);

    always_comb begin
        sel = FWD_RF;
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage pipeline,
// with data-memory wait sequencing and a timeout fault.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             id_valid,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_wb_en,
    input  logic             ex_is_load,
    input  logic             ex_redirect,
    input  logic [4:0]       mem_rd,
    input  logic [4:0]       wb_rd,
    input  logic             mem_wb_en,
    input  logic             wb_wb_en,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en_o,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             mem_fault,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

    state_t            state_q;
    state_t            state_d;
    logic [WCNT_W-1:0] wait_cnt_q;
    logic [WCNT_W-1:0] wait_cnt_d;
    logic              mem_fault_q;
    logic [CNT_W-1:0]  stall_q;

    logic       rs1_hit;
    logic       rs2_hit;
    logic       load_use;
    logic       freeze;
    logic       in_fault;
    logic [4:0] en;
    logic [1:0] fwd_a_raw;
    logic [1:0] fwd_b_raw;

    assign rs1_hit  = id_rs1_used && (id_rs1 == ex_rd);
    assign rs2_hit  = id_rs2_used && (id_rs2 == ex_rd);
    assign load_use = id_valid && ex_wb_en && ex_is_load &&
                      (ex_rd != 5'd0) && (rs1_hit || rs2_hit);

    assign freeze = ((state_q == RUN) && mem_req && !mem_ready) ||
                    ((state_q == MEM_WAIT) && !mem_ready);
    assign in_fault = (state_q == FAULT);

    // Arbitration order matters: later arms only apply when earlier are idle.
    always_comb begin
        en          = 5'b11111;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        priority case (1'b1)
            rst: begin
                en          = 5'b00000;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end
            in_fault: en = 5'b00000;
            freeze:   en = 5'b00000;
            ex_redirect: begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end
            load_use: begin
                en          = 5'b00111;
                id_ex_flush = 1'b1;
            end
            default: ;
        endcase
    end

    assign {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en_o} = en;

    fwd_unit u_fwd_a (
        .ex_rs     (ex_rs1),
        .mem_rd    (mem_rd),
        .mem_wb_en (mem_wb_en),
        .wb_rd     (wb_rd),
        .wb_wb_en  (wb_wb_en),
        .sel       (fwd_a_raw)
    );

    fwd_unit u_fwd_b (
        .ex_rs     (ex_rs2),
        .mem_rd    (mem_rd),
        .mem_wb_en (mem_wb_en),
        .wb_rd     (wb_rd),
        .wb_wb_en  (wb_wb_en),
        .sel       (fwd_b_raw)
    );

    assign fwd_a_sel = rst ? FWD_RF : fwd_a_raw;
    assign fwd_b_sel = rst ? FWD_RF : fwd_b_raw;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WCNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WCNT_W'(MEM_TIMEOUT)) begin
                    state_d = FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                end
            end
            FAULT: ;
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            mem_fault_q <= 1'b0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_fault_q <= mem_fault_q || (state_d == FAULT);
            if (!in_fault && !pc_en && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    assign mem_fault    = mem_fault_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: vector table plus
// hand-written reset, memory-wait, timeout and redirect sequences.
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2;
    logic        id_rs1_used, id_rs2_used, id_valid;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic        ex_wb_en, ex_is_load, ex_redirect;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_wb_en, wb_wb_en;
    logic        mem_req, mem_ready;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en_o;
    logic        if_id_flush, id_ex_flush;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic        mem_fault;
    logic [31:0] stall_cycles;

    int checks;
    int errors;
    int exp_stall;

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT (4),
        .CNT_W       (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .id_valid     (id_valid),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ex_rd        (ex_rd),
        .ex_wb_en     (ex_wb_en),
        .ex_is_load   (ex_is_load),
        .ex_redirect  (ex_redirect),
        .mem_rd       (mem_rd),
        .wb_rd        (wb_rd),
        .mem_wb_en    (mem_wb_en),
        .wb_wb_en     (wb_wb_en),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .id_ex_en     (id_ex_en),
        .ex_mem_en    (ex_mem_en),
        .mem_wb_en_o  (mem_wb_en_o),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .mem_fault    (mem_fault),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] id_rs1;
        logic [4:0] id_rs2;
        logic       r1u;
        logic       r2u;
        logic       idv;
        logic [4:0] ex_rs1;
        logic [4:0] ex_rs2;
        logic [4:0] ex_rd;
        logic       ex_wb;
        logic       ld;
        logic       redir;
        logic [4:0] mem_rd;
        logic       mem_we;
        logic [4:0] wb_rd;
        logic       wb_we;
        logic [4:0] en;
        logic [1:0] fl;
        logic [1:0] fa;
        logic [1:0] fb;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    function automatic logic [4:0] en_now();
        return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en_o};
    endfunction

    function automatic logic [1:0] fl_now();
        return {if_id_flush, id_ex_flush};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1 = 0; id_rs2 = 0;
        id_rs1_used = 0; id_rs2_used = 0; id_valid = 0;
        ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0;
        ex_wb_en = 0; ex_is_load = 0; ex_redirect = 0;
        mem_rd = 0; wb_rd = 0; mem_wb_en = 0; wb_wb_en = 0;
        mem_req = 0; mem_ready = 1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_stall = 0;

        vecs[0]  = '{0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0, 5'b11111,2'b00,2'b00,2'b00};
        vecs[1]  = '{5,0,1,0,1, 0,0,5, 1,1,0, 0,0,0,0, 5'b00111,2'b01,2'b00,2'b00};
        vecs[2]  = '{0,0,1,0,1, 0,0,0, 1,1,0, 0,0,0,0, 5'b11111,2'b00,2'b00,2'b00};
        vecs[3]  = '{0,9,0,1,1, 0,0,9, 1,1,0, 0,0,0,0, 5'b00111,2'b01,2'b00,2'b00};
        vecs[4]  = '{0,9,0,0,1, 0,0,9, 1,1,0, 0,0,0,0, 5'b11111,2'b00,2'b00,2'b00};
        vecs[5]  = '{5,0,1,0,1, 0,0,5, 1,0,0, 0,0,0,0, 5'b11111,2'b00,2'b00,2'b00};
        vecs[6]  = '{5,0,1,0,0, 0,0,5, 1,1,0, 0,0,0,0, 5'b11111,2'b00,2'b00,2'b00};
        vecs[7]  = '{5,0,1,0,1, 0,0,5, 1,1,1, 0,0,0,0, 5'b11111,2'b11,2'b00,2'b00};
        vecs[8]  = '{0,0,0,0,0, 0,0,0, 0,0,1, 0,0,0,0, 5'b11111,2'b11,2'b00,2'b00};
        vecs[9]  = '{0,0,0,0,0, 7,0,0, 0,0,0, 7,1,7,1, 5'b11111,2'b00,2'b01,2'b00};
        vecs[10] = '{0,0,0,0,0, 7,0,0, 0,0,0, 7,0,7,1, 5'b11111,2'b00,2'b10,2'b00};
        vecs[11] = '{0,0,0,0,0, 0,0,0, 0,0,0, 0,1,0,1, 5'b11111,2'b00,2'b00,2'b00};
        vecs[12] = '{0,0,0,0,0, 4,3,0, 0,0,0, 4,1,3,1, 5'b11111,2'b00,2'b01,2'b10};
        vecs[13] = '{5,0,1,0,1, 0,0,5, 0,1,0, 0,0,0,0, 5'b11111,2'b00,2'b00,2'b00};

        clear_inputs();
        rst       = 1'b1;
        ex_rs1    = 7;
        mem_rd    = 7;
        mem_wb_en = 1;

        #3;
        chk("rst_en", 32'(en_now()), 32'h00);
        chk("rst_flush", 32'(fl_now()), 32'h3);
        chk("rst_fwd_a", 32'(fwd_a_sel), 32'h0);
        chk("rst_fault", 32'(mem_fault), 32'h0);

        next_cycle();
        next_cycle();
        rst = 1'b0;
        #2;
        chk("post_rst_en", 32'(en_now()), 32'h1f);
        chk("post_rst_flush", 32'(fl_now()), 32'h0);
        chk("post_rst_stall", stall_cycles, 32'd0);
        chk("post_rst_fwd_a", 32'(fwd_a_sel), 32'h1);

        for (int i = 0; i < NV; i++) begin
            next_cycle();
            clear_inputs();
            id_rs1      = vecs[i].id_rs1;
            id_rs2      = vecs[i].id_rs2;
            id_rs1_used = vecs[i].r1u;
            id_rs2_used = vecs[i].r2u;
            id_valid    = vecs[i].idv;
            ex_rs1      = vecs[i].ex_rs1;
            ex_rs2      = vecs[i].ex_rs2;
            ex_rd       = vecs[i].ex_rd;
            ex_wb_en    = vecs[i].ex_wb;
            ex_is_load  = vecs[i].ld;
            ex_redirect = vecs[i].redir;
            mem_rd      = vecs[i].mem_rd;
            mem_wb_en   = vecs[i].mem_we;
            wb_rd       = vecs[i].wb_rd;
            wb_wb_en    = vecs[i].wb_we;
            #2;
            chk($sformatf("v%0d_en", i), 32'(en_now()), 32'(vecs[i].en));
            chk($sformatf("v%0d_flush", i), 32'(fl_now()), 32'(vecs[i].fl));
            chk($sformatf("v%0d_fwd_a", i), 32'(fwd_a_sel), 32'(vecs[i].fa));
            chk($sformatf("v%0d_fwd_b", i), 32'(fwd_b_sel), 32'(vecs[i].fb));
            if (!vecs[i].en[4]) exp_stall++;
        end
        next_cycle();
        clear_inputs();
        #2;
        chk("table_stall", stall_cycles, 32'(exp_stall));

        // Access completing in the request cycle costs nothing
        mem_req   = 1;
        mem_ready = 1;
        #1;
        chk("zero_wait_en", 32'(en_now()), 32'h1f);
        next_cycle();
        chk("zero_wait_stall", stall_cycles, 32'(exp_stall));

        // Three frozen cycles, redirect held off until ready
        mem_ready = 0;
        #2;
        chk("mw0_en", 32'(en_now()), 32'h00);
        chk("mw0_flush", 32'(fl_now()), 32'h0);
        next_cycle();
        ex_redirect = 1;
        #2;
        chk("mw1_en", 32'(en_now()), 32'h00);
        chk("mw1_flush", 32'(fl_now()), 32'h0);
        next_cycle();
        #2;
        chk("mw2_en", 32'(en_now()), 32'h00);
        chk("mw2_flush", 32'(fl_now()), 32'h0);
        next_cycle();
        mem_ready = 1;
        #2;
        chk("mw_ready_en", 32'(en_now()), 32'h1f);
        chk("mw_ready_flush", 32'(fl_now()), 32'h3);
        next_cycle();
        mem_req     = 0;
        ex_redirect = 0;
        exp_stall  += 3;
        #2;
        chk("mw_done_en", 32'(en_now()), 32'h1f);
        chk("mw_stall", stall_cycles, 32'(exp_stall));

        // Timeout: 5 frozen cycles with MEM_TIMEOUT=4
        mem_req   = 1;
        mem_ready = 0;
        for (int k = 0; k < 5; k++) begin
            #2;
            chk($sformatf("to%0d_en", k), 32'(en_now()), 32'h00);
            chk($sformatf("to%0d_fault", k), 32'(mem_fault), 32'h0);
            next_cycle();
        end
        exp_stall += 5;
        #2;
        chk("fault_set", 32'(mem_fault), 32'h1);
        chk("fault_en", 32'(en_now()), 32'h00);
        chk("fault_flush", 32'(fl_now()), 32'h0);
        chk("fault_stall", stall_cycles, 32'(exp_stall));
        mem_req   = 0;
        mem_ready = 1;
        next_cycle();
        next_cycle();
        #2;
        chk("fault_sticky", 32'(mem_fault), 32'h1);
        chk("fault_hold_en", 32'(en_now()), 32'h00);
        chk("fault_stall_hold", stall_cycles, 32'(exp_stall));

        rst = 1'b1;
        #1;
        chk("rst2_en", 32'(en_now()), 32'h00);
        chk("rst2_flush", 32'(fl_now()), 32'h3);
        chk("rst2_fault", 32'(mem_fault), 32'h0);
        chk("rst2_stall", stall_cycles, 32'd0);
        next_cycle();
        rst = 1'b0;
        #2;
        chk("rst2_rel_en", 32'(en_now()), 32'h1f);
        chk("rst2_rel_fault", 32'(mem_fault), 32'h0);
        next_cycle();
        chk("rst2_rel_stall", stall_cycles, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
